// File: rtl/cfu_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : cfu_cmd_queue
// Description : Command/response buffering stage in front of the PIM CFU.
//               Host commands are queued and issued to the CFU in order under
//               a credit limit. The credit limit guarantees that every CFU
//               response has a slot in the response FIFO. Each response is
//               stored with the function_id that produced it, so the host can
//               drain both together.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Optional feature macro: CFU_POSTED_WRITE_EN
//   When defined, write commands (function_id[1:0] == 2'b01) are posted:
//   - their CFU response is consumed and dropped;
//   - they reserve no response-FIFO credit.
// ----------------------------------------------------------------------------
// Ports
//   clk, reset_n                 : clock (rising edge), async active-low reset
//   host_cmd_*                   : host command push (valid/ready + payload)
//   cfu_cmd_*                    : command issue towards the CFU
//   cfu_rsp_*                    : CFU response (ready is always 1)
//   host_rsp_*                   : buffered response + producing function_id
//   outstanding                  : commands issued, response not yet received
//   err_unexp                    : sticky, response seen with nothing in flight
//   idle                         : all FIFOs empty and nothing in flight
// ============================================================================
module cfu_cmd_queue #(
  parameter int DWIDTH   = 32,
  parameter int AWIDTH   = 10,
  parameter int CQ_DEPTH = 4,
  parameter int RQ_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  // host command side
  input  logic                        host_cmd_valid,
  output logic                        host_cmd_ready,
  input  logic [AWIDTH-1:0]           host_cmd_function_id,
  input  logic [DWIDTH-1:0]           host_cmd_inputs_0,
  input  logic [DWIDTH-1:0]           host_cmd_inputs_1,
  // CFU command side
  output logic                        cfu_cmd_valid,
  input  logic                        cfu_cmd_ready,
  output logic [AWIDTH-1:0]           cfu_cmd_payload_function_id,
  output logic [DWIDTH-1:0]           cfu_cmd_payload_inputs_0,
  output logic [DWIDTH-1:0]           cfu_cmd_payload_inputs_1,
  // CFU response side
  input  logic                        cfu_rsp_valid,
  output logic                        cfu_rsp_ready,
  input  logic [DWIDTH-1:0]           cfu_rsp_payload_outputs_0,
  // host response side
  output logic                        host_rsp_valid,
  input  logic                        host_rsp_ready,
  output logic [DWIDTH-1:0]           host_rsp_data,
  output logic [AWIDTH-1:0]           host_rsp_function_id,
  // status
  output logic [$clog2(RQ_DEPTH):0]   outstanding,
  output logic                        err_unexp,
  output logic                        idle
);

  localparam int c_cq_pw = $clog2(CQ_DEPTH);     // command FIFO pointer width
  localparam int c_rq_pw = $clog2(RQ_DEPTH);     // response/tag pointer width
  localparam int c_cq_cw = c_cq_pw + 1;          // command FIFO count width
  localparam int c_rq_cw = c_rq_pw + 1;          // response count / credit width

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [AWIDTH-1:0]  r_cq_fid  [CQ_DEPTH];
  logic [DWIDTH-1:0]  r_cq_in0  [CQ_DEPTH];
  logic [DWIDTH-1:0]  r_cq_in1  [CQ_DEPTH];
  logic [c_cq_pw-1:0] r_cq_wptr;
  logic [c_cq_pw-1:0] r_cq_rptr;
  logic [c_cq_cw-1:0] r_cq_count;

  // Tag FIFO: its occupancy is exactly the outstanding count.
  logic [AWIDTH-1:0]  r_tag_fid [RQ_DEPTH];
  logic [c_rq_pw-1:0] r_tag_wptr;
  logic [c_rq_pw-1:0] r_tag_rptr;
  logic [c_rq_cw-1:0] r_outstanding;

  logic [AWIDTH-1:0]  r_rq_fid  [RQ_DEPTH];
  logic [DWIDTH-1:0]  r_rq_data [RQ_DEPTH];
  logic [c_rq_pw-1:0] r_rq_wptr;
  logic [c_rq_pw-1:0] r_rq_rptr;
  logic [c_rq_cw-1:0] r_rq_count;

  logic               r_err_unexp;

`ifdef CFU_POSTED_WRITE_EN
  logic               r_tag_drop [RQ_DEPTH];
`endif

  // --------------------------------------------------------------------------
  // Handshake and credit decode
  // --------------------------------------------------------------------------
  logic               w_cq_empty;
  logic               w_cq_full;
  logic               w_cq_push;
  logic [c_rq_cw:0]   w_credit_sum;
  logic               w_credit_ok;
  logic               w_issue_ok;
  logic               w_cmd_valid;
  logic               w_issue;
  logic               w_rsp_hit;
  logic               w_rsp_unexp;
  logic               w_rq_push;
  logic               w_rq_pop;
  logic               w_rsp_valid;

  assign w_cq_empty = (r_cq_count == '0);
  assign w_cq_full  = (r_cq_count == c_cq_cw'(CQ_DEPTH));
  assign w_cq_push  = host_cmd_valid && !w_cq_full;

  // One extra bit so the sum of two full-scale counts cannot wrap.
  assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, r_rq_count};
  assign w_credit_ok  = (w_credit_sum < (c_rq_cw + 1)'(RQ_DEPTH));

`ifdef CFU_POSTED_WRITE_EN
  logic w_head_posted;
  logic w_tag_head_drop;
  assign w_head_posted   = (r_cq_fid[r_cq_rptr][1:0] == 2'b01);
  assign w_tag_head_drop = r_tag_drop[r_tag_rptr];
  // A posted write needs only a tag slot, not a response slot.
  assign w_issue_ok = w_head_posted ? (r_outstanding < c_rq_cw'(RQ_DEPTH))
                                    : w_credit_ok;
  assign w_rq_push  = w_rsp_hit && !w_tag_head_drop;
`else
  assign w_issue_ok = w_credit_ok;
  assign w_rq_push  = w_rsp_hit;
`endif

  assign w_cmd_valid = !w_cq_empty && w_issue_ok;
  assign w_issue     = w_cmd_valid && cfu_cmd_ready;

  // Response space is guaranteed by the credit rule, so always accept.
  assign w_rsp_hit   = cfu_rsp_valid && (r_outstanding != '0);
  assign w_rsp_unexp = cfu_rsp_valid && (r_outstanding == '0);

  assign w_rsp_valid = (r_rq_count != '0);
  assign w_rq_pop    = w_rsp_valid && host_rsp_ready;

  // --------------------------------------------------------------------------
  // Command FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < CQ_DEPTH; i++) begin
        r_cq_fid[i] <= '0;
        r_cq_in0[i] <= '0;
        r_cq_in1[i] <= '0;
      end
      r_cq_wptr  <= '0;
      r_cq_rptr  <= '0;
      r_cq_count <= '0;
    end else begin
      if (w_cq_push) begin
        r_cq_fid[r_cq_wptr] <= host_cmd_function_id;
        r_cq_in0[r_cq_wptr] <= host_cmd_inputs_0;
        r_cq_in1[r_cq_wptr] <= host_cmd_inputs_1;
        r_cq_wptr           <= r_cq_wptr + 1'b1;
      end
      if (w_issue) begin
        r_cq_rptr <= r_cq_rptr + 1'b1;
      end
      case ({w_cq_push, w_issue})
        2'b10:   r_cq_count <= r_cq_count + 1'b1;
        2'b01:   r_cq_count <= r_cq_count - 1'b1;
        default: r_cq_count <= r_cq_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Tag FIFO and outstanding counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RQ_DEPTH; i++) begin
        r_tag_fid[i] <= '0;
`ifdef CFU_POSTED_WRITE_EN
        r_tag_drop[i] <= 1'b0;
`endif
      end
      r_tag_wptr    <= '0;
      r_tag_rptr    <= '0;
      r_outstanding <= '0;
    end else begin
      if (w_issue) begin
        r_tag_fid[r_tag_wptr] <= r_cq_fid[r_cq_rptr];
`ifdef CFU_POSTED_WRITE_EN
        r_tag_drop[r_tag_wptr] <= w_head_posted;
`endif
        r_tag_wptr <= r_tag_wptr + 1'b1;
      end
      if (w_rsp_hit) begin
        r_tag_rptr <= r_tag_rptr + 1'b1;
      end
      case ({w_issue, w_rsp_hit})
        2'b10:   r_outstanding <= r_outstanding + 1'b1;
        2'b01:   r_outstanding <= r_outstanding - 1'b1;
        default: r_outstanding <= r_outstanding;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Response FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < RQ_DEPTH; i++) begin
        r_rq_fid[i]  <= '0;
        r_rq_data[i] <= '0;
      end
      r_rq_wptr  <= '0;
      r_rq_rptr  <= '0;
      r_rq_count <= '0;
    end else begin
      if (w_rq_push) begin
        r_rq_fid[r_rq_wptr]  <= r_tag_fid[r_tag_rptr];
        r_rq_data[r_rq_wptr] <= cfu_rsp_payload_outputs_0;
        r_rq_wptr            <= r_rq_wptr + 1'b1;
      end
      if (w_rq_pop) begin
        r_rq_rptr <= r_rq_rptr + 1'b1;
      end
      case ({w_rq_push, w_rq_pop})
        2'b10:   r_rq_count <= r_rq_count + 1'b1;
        2'b01:   r_rq_count <= r_rq_count - 1'b1;
        default: r_rq_count <= r_rq_count;
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Sticky unexpected-response flag
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_err_unexp <= 1'b0;
    end else if (w_rsp_unexp) begin
      r_err_unexp <= 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign host_cmd_ready              = !w_cq_full;
  assign cfu_cmd_valid               = w_cmd_valid;
  assign cfu_cmd_payload_function_id = r_cq_fid[r_cq_rptr];
  assign cfu_cmd_payload_inputs_0    = r_cq_in0[r_cq_rptr];
  assign cfu_cmd_payload_inputs_1    = r_cq_in1[r_cq_rptr];
  assign cfu_rsp_ready               = 1'b1;
  assign host_rsp_valid              = w_rsp_valid;
  assign host_rsp_data               = r_rq_data[r_rq_rptr];
  assign host_rsp_function_id        = r_rq_fid[r_rq_rptr];
  assign outstanding                 = r_outstanding;
  assign err_unexp                   = r_err_unexp;
  assign idle                        = w_cq_empty && !w_rsp_valid &&
                                       (r_outstanding == '0);

endmodule
`default_nettype wire

// File: tb/tb_cfu_cmd_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_cfu_cmd_queue
// Description : Directed self-checking bench for cfu_cmd_queue
//               (DWIDTH=32, AWIDTH=10, CQ_DEPTH=4, RQ_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cfu_cmd_queue;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        host_cmd_valid;
  logic        host_cmd_ready;
  logic [9:0]  host_cmd_function_id;
  logic [31:0] host_cmd_inputs_0;
  logic [31:0] host_cmd_inputs_1;
  logic        cfu_cmd_valid;
  logic        cfu_cmd_ready;
  logic [9:0]  cfu_cmd_payload_function_id;
  logic [31:0] cfu_cmd_payload_inputs_0;
  logic [31:0] cfu_cmd_payload_inputs_1;
  logic        cfu_rsp_valid;
  logic        cfu_rsp_ready;
  logic [31:0] cfu_rsp_payload_outputs_0;
  logic        host_rsp_valid;
  logic        host_rsp_ready;
  logic [31:0] host_rsp_data;
  logic [9:0]  host_rsp_function_id;
  logic [2:0]  outstanding;
  logic        err_unexp;
  logic        idle;

  int checks = 0;
  int errors = 0;

  cfu_cmd_queue #(
    .DWIDTH(32), .AWIDTH(10), .CQ_DEPTH(4), .RQ_DEPTH(4)
  ) dut (
    .clk                         (clk),
    .reset_n                     (reset_n),
    .host_cmd_valid              (host_cmd_valid),
    .host_cmd_ready              (host_cmd_ready),
    .host_cmd_function_id        (host_cmd_function_id),
    .host_cmd_inputs_0           (host_cmd_inputs_0),
    .host_cmd_inputs_1           (host_cmd_inputs_1),
    .cfu_cmd_valid               (cfu_cmd_valid),
    .cfu_cmd_ready               (cfu_cmd_ready),
    .cfu_cmd_payload_function_id (cfu_cmd_payload_function_id),
    .cfu_cmd_payload_inputs_0    (cfu_cmd_payload_inputs_0),
    .cfu_cmd_payload_inputs_1    (cfu_cmd_payload_inputs_1),
    .cfu_rsp_valid               (cfu_rsp_valid),
    .cfu_rsp_ready               (cfu_rsp_ready),
    .cfu_rsp_payload_outputs_0   (cfu_rsp_payload_outputs_0),
    .host_rsp_valid              (host_rsp_valid),
    .host_rsp_ready              (host_rsp_ready),
    .host_rsp_data               (host_rsp_data),
    .host_rsp_function_id        (host_rsp_function_id),
    .outstanding                 (outstanding),
    .err_unexp                   (err_unexp),
    .idle                        (idle)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; outputs are sampled and inputs driven
  // 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Read-type function_ids (bits[1:0] == 2'b00), distinct per index.
  function automatic logic [9:0] fid_of(input int i);
    return 10'h040 + 10'(i * 4);
  endfunction

  logic [31:0] exp_data [3];
  logic [9:0]  exp_fid  [3];

  initial begin
    reset_n                   = 1'b0;
    host_cmd_valid            = 1'b0;
    host_cmd_function_id      = '0;
    host_cmd_inputs_0         = '0;
    host_cmd_inputs_1         = '0;
    cfu_cmd_ready             = 1'b0;
    cfu_rsp_valid             = 1'b0;
    cfu_rsp_payload_outputs_0 = '0;
    host_rsp_ready            = 1'b0;

    // ---------------- reset state ----------------
    repeat (2) tick();
    chk("rst_idle",      64'(idle), 64'(1));
    chk("rst_cmd_valid", 64'(cfu_cmd_valid), 64'(0));
    chk("rst_rsp_valid", 64'(host_rsp_valid), 64'(0));
    chk("rst_outst",     64'(outstanding), 64'(0));
    chk("rst_err",       64'(err_unexp), 64'(0));
    chk("rst_cmd_ready", 64'(host_cmd_ready), 64'(1));
    chk("rst_payload",   64'(cfu_cmd_payload_inputs_0), 64'(0));
    reset_n = 1'b1;
    tick();
    chk("rsp_ready_one", 64'(cfu_rsp_ready), 64'(1));

    // ---------------- single command/response ----------------
    cfu_cmd_ready        = 1'b1;
    host_cmd_valid       = 1'b1;
    host_cmd_function_id = 10'h005;
    host_cmd_inputs_0    = 32'hDEADBEEF;
    host_cmd_inputs_1    = 32'hCAFEF00D;
    chk("t2_no_bypass", 64'(cfu_cmd_valid), 64'(0));
    tick();
    host_cmd_valid = 1'b0;
    chk("t2_valid",  64'(cfu_cmd_valid), 64'(1));
    chk("t2_fid",    64'(cfu_cmd_payload_function_id), 64'(10'h005));
    chk("t2_in0",    64'(cfu_cmd_payload_inputs_0), 64'(32'hDEADBEEF));
    chk("t2_in1",    64'(cfu_cmd_payload_inputs_1), 64'(32'hCAFEF00D));
    tick();
    chk("t2_issued", 64'(cfu_cmd_valid), 64'(0));
    chk("t2_outst1", 64'(outstanding), 64'(1));
    cfu_rsp_valid             = 1'b1;
    cfu_rsp_payload_outputs_0 = 32'h0000_1234;
    chk("t2_rsp_not_yet", 64'(host_rsp_valid), 64'(0));
    tick();
    cfu_rsp_valid = 1'b0;
`ifdef CFU_POSTED_WRITE_EN
    chk("t2p_no_rsp", 64'(host_rsp_valid), 64'(0));
    chk("t2p_outst0", 64'(outstanding), 64'(0));
    chk("t2p_idle",   64'(idle), 64'(1));
`else
    chk("t2_rsp_valid", 64'(host_rsp_valid), 64'(1));
    chk("t2_rsp_data",  64'(host_rsp_data), 64'(32'h0000_1234));
    chk("t2_rsp_fid",   64'(host_rsp_function_id), 64'(10'h005));
    chk("t2_outst0",    64'(outstanding), 64'(0));
    tick();
    chk("t2_rsp_hold",  64'(host_rsp_data), 64'(32'h0000_1234));
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
    chk("t2_drained",   64'(host_rsp_valid), 64'(0));
    chk("t2_idle",      64'(idle), 64'(1));
`endif

    // ---------------- command FIFO full, CFU stalled ----------------
    cfu_cmd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      host_cmd_valid       = 1'b1;
      host_cmd_function_id = fid_of(i);
      host_cmd_inputs_0    = 32'h1000_0000 + 32'(i);
      host_cmd_inputs_1    = 32'h2000_0000 + 32'(i);
      chk("t3_cmd_ready", 64'(host_cmd_ready), 64'(i < 4));
      tick();
      chk("t3_hold_fid", 64'(cfu_cmd_payload_function_id), 64'(fid_of(0)));
      chk("t3_hold_vld", 64'(cfu_cmd_valid), 64'(1));
    end
    host_cmd_valid = 1'b0;
    chk("t3_full", 64'(host_cmd_ready), 64'(0));
    cfu_cmd_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_order_fid", 64'(cfu_cmd_payload_function_id), 64'(fid_of(k)));
      chk("t3_order_in0", 64'(cfu_cmd_payload_inputs_0),
          64'(32'h1000_0000 + 32'(k)));
      tick();
    end
    chk("t3_empty_vld", 64'(cfu_cmd_valid), 64'(0));
    chk("t3_outst4",    64'(outstanding), 64'(4));
    for (int k = 0; k < 4; k++) begin
      cfu_rsp_valid             = 1'b1;
      cfu_rsp_payload_outputs_0 = 32'h0000_2000 + 32'(k);
      tick();
    end
    cfu_rsp_valid = 1'b0;
    chk("t3_outst0", 64'(outstanding), 64'(0));
    host_rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("t3_rsp_vld",  64'(host_rsp_valid), 64'(1));
      chk("t3_rsp_data", 64'(host_rsp_data), 64'(32'h0000_2000 + 32'(k)));
      chk("t3_rsp_fid",  64'(host_rsp_function_id), 64'(fid_of(k)));
      tick();
    end
    host_rsp_ready = 1'b0;
    chk("t3_idle", 64'(idle), 64'(1));

    // ---------------- credit limit with host stalled ----------------
    for (int i = 0; i < 5; i++) begin
      host_cmd_valid       = 1'b1;
      host_cmd_function_id = fid_of(i + 8);
      host_cmd_inputs_0    = 32'h3000_0000 + 32'(i);
      tick();
    end
    host_cmd_valid = 1'b0;
    chk("t4_blocked",   64'(cfu_cmd_valid), 64'(0));
    chk("t4_outst4",    64'(outstanding), 64'(4));
    chk("t4_head_fid",  64'(cfu_cmd_payload_function_id), 64'(fid_of(12)));
    for (int k = 0; k < 4; k++) begin
      cfu_rsp_valid             = 1'b1;
      cfu_rsp_payload_outputs_0 = 32'h0000_00A0 + 32'(k);
      tick();
    end
    cfu_rsp_valid = 1'b0;
    chk("t4_rq_full_blk", 64'(cfu_cmd_valid), 64'(0));
    chk("t4_outst0",      64'(outstanding), 64'(0));
    chk("t4_head_data",   64'(host_rsp_data), 64'(32'h0000_00A0));
    host_rsp_ready = 1'b1;
    tick();
    host_rsp_ready = 1'b0;
    chk("t4_unblocked",  64'(cfu_cmd_valid), 64'(1));
    chk("t4_next_data",  64'(host_rsp_data), 64'(32'h0000_00A1));
    tick();
    chk("t4_5th_issued", 64'(outstanding), 64'(1));
    chk("t4_cq_empty",   64'(cfu_cmd_valid), 64'(0));
    // Simultaneous host pop and CFU response.
    host_rsp_ready            = 1'b1;
    cfu_rsp_valid             = 1'b1;
    cfu_rsp_payload_outputs_0 = 32'h0000_00B4;
    tick();
    cfu_rsp_valid = 1'b0;
    chk("t4_outst_after", 64'(outstanding), 64'(0));
    exp_data[0] = 32'h0000_00A2; exp_fid[0] = fid_of(10);
    exp_data[1] = 32'h0000_00A3; exp_fid[1] = fid_of(11);
    exp_data[2] = 32'h0000_00B4; exp_fid[2] = fid_of(12);
    for (int k = 0; k < 3; k++) begin
      chk("t4_drain_vld",  64'(host_rsp_valid), 64'(1));
      chk("t4_drain_data", 64'(host_rsp_data), 64'(exp_data[k]));
      chk("t4_drain_fid",  64'(host_rsp_function_id), 64'(exp_fid[k]));
      tick();
    end
    host_rsp_ready = 1'b0;
    chk("t4_drain_empty", 64'(host_rsp_valid), 64'(0));
    chk("t4_idle",        64'(idle), 64'(1));

    // ---------------- unexpected response ----------------
    cfu_rsp_valid             = 1'b1;
    cfu_rsp_payload_outputs_0 = 32'hFFFF_FFFF;
    tick();
    cfu_rsp_valid = 1'b0;
    chk("t5_err",       64'(err_unexp), 64'(1));
    chk("t5_no_rsp",    64'(host_rsp_valid), 64'(0));
    chk("t5_outst",     64'(outstanding), 64'(0));
    repeat (2) tick();
    chk("t5_err_stick", 64'(err_unexp), 64'(1));

    // ---------------- asynchronous reset mid-stream ----------------
    for (int i = 0; i < 5; i++) begin
      host_cmd_valid       = 1'b1;
      host_cmd_function_id = fid_of(16 + i);
      host_cmd_inputs_0    = 32'h4000_0000 + 32'(i);
      cfu_cmd_ready        = (i < 3);
      tick();
    end
    host_cmd_valid = 1'b0;
    cfu_cmd_ready  = 1'b0;
    chk("t6_outst2",   64'(outstanding), 64'(2));
    chk("t6_head_fid", 64'(cfu_cmd_payload_function_id), 64'(fid_of(18)));
    chk("t6_not_idle", 64'(idle), 64'(0));
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_outst_rst", 64'(outstanding), 64'(0));
    chk("t6_idle_rst",  64'(idle), 64'(1));
    chk("t6_vld_rst",   64'(cfu_cmd_valid), 64'(0));
    chk("t6_err_rst",   64'(err_unexp), 64'(0));
    chk("t6_fid_rst",   64'(cfu_cmd_payload_function_id), 64'(0));
    chk("t6_rdy_rst",   64'(host_cmd_ready), 64'(1));
    tick();
    reset_n = 1'b1;
    tick();
    cfu_rsp_valid             = 1'b1;
    cfu_rsp_payload_outputs_0 = 32'h0000_5555;
    tick();
    cfu_rsp_valid = 1'b0;
    chk("t6_late_err", 64'(err_unexp), 64'(1));
    chk("t6_late_rsp", 64'(host_rsp_valid), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
